apb_arb_master: RTL and testbench
=================================

Name: apb_arb_master

Overview:
- APB master that shares one APB slave port (the apbif register block) between two on-chip requesters, e.g. the rotate DMA/config sequencer and the host bridge.
- Arbitrates with round-robin priority and sequences the standard IDLE -> SETUP -> ACCESS protocol, including PREADY wait states.
- Returns one response per transfer (read data, requester ID and error flag) to the requester that was granted.

Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYC, 16, ACCESS-phase cycles before abort; used only with APB_TIMEOUT_EN

Ports:
- I_PCLK  in  1  single clock, all logic on rising edge
- I_PRESET_N  in  1  reset, asynchronous assert, active-low
- I_REQ_VALID  in  2  per-requester request valid; bit i = requester i
- I_REQ_WRITE  in  2  per-requester write(1)/read(0)
- I_REQ_ADDR  in  2*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
- I_REQ_WDATA  in  2*DATA_W  requester i at [i*DATA_W +: DATA_W]
- O_REQ_READY  out  2  one-hot accept pulse; request consumed in that cycle
- O_RSP_VALID  out  1  one-cycle response pulse
- O_RSP_ID  out  1  requester index of the response
- O_RSP_RDATA  out  DATA_W  captured I_PRDATA for reads; 0 for writes
- O_RSP_ERR  out  1  transfer aborted by timeout
- O_PSEL, O_PENABLE, O_PWRITE  out  1 each  APB control
- O_PADDR  out  ADDR_W  APB address
- O_PWDATA  out  DATA_W  APB write data
- I_PRDATA  in  DATA_W  APB read data
- I_PREADY  in  1  APB ready

Behaviour:
- Clock and reset: one clock (I_PCLK); I_PRESET_N is asynchronous, active-low. While in reset, every registered output is 0, the FSM is in IDLE and the RR pointer is 0, so requester 0 wins first.
- FSM states (2-bit): IDLE, SETUP, ACCESS.
- IDLE
  - If any I_REQ_VALID is high, the arbiter grants one requester and O_REQ_READY[g]=1 combinationally in that cycle.
  - The cmd regs (write, addr, wdata, id) latch from requester g, and the FSM moves to SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the cmd regs. Always lasts exactly 1 cycle, then ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Address, control and data stay stable until I_PREADY=1 is sampled.
- On PREADY=1 in ACCESS:
  - Capture I_PRDATA (reads only) into O_RSP_RDATA.
  - Pulse O_RSP_VALID next cycle, with O_RSP_ID = cmd id and O_RSP_ERR=0.
  - If any I_REQ_VALID is high in the same cycle, grant again (O_REQ_READY pulses that cycle) and go straight to SETUP. PSEL stays 1 and PENABLE drops, giving back-to-back transfers with no idle cycle. Otherwise go to IDLE with PSEL=0 and PENABLE=0.
- Arbitration, round-robin over 2 requesters:
  - If both request, the one not granted last wins.
  - The pointer updates only on an actual grant.
  - A single requester always wins, regardless of the pointer.
- Requester rule: hold VALID and payload stable until READY. Deasserting VALID before READY withdraws the request, which is legal in IDLE only.
- Latency, request accepted in IDLE at cycle 0 with zero-wait slave: PSEL at 1, PENABLE at 2, O_RSP_VALID at 3. Each PREADY wait cycle adds 1.
- Reset asserted mid-transfer drops PSEL/PENABLE at once. The in-flight command is lost and no response is issued.
- O_PADDR/O_PWDATA/O_PWRITE keep their last values in IDLE. O_RSP_RDATA holds until the next response.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ACCESS and counts each ACCESS cycle with PREADY=0.
  - On reaching TIMEOUT_CYC, the FSM forces PSEL=0 and PENABLE=0 and goes to IDLE (no back-to-back).
  - It then pulses O_RSP_VALID with O_RSP_ERR=1 and O_RSP_RDATA=0.
- When not defined: ACCESS waits indefinitely, no counter exists, and O_RSP_ERR is tied to 0.

Decomposition:
- Package apb_arb_pkg holds:
  - state localparams ST_IDLE=2'b00, ST_SETUP=2'b01, ST_ACCESS=2'b10
  - default widths
  - counter width (clog2 of TIMEOUT_CYC+1)
- Sub-module rr_arb2 is a combinational 2-way round-robin grant plus a registered last-grant pointer, update-on-grant input. The top level holds the FSM, cmd regs, response regs and timeout counter.

Test Plan:
- Req0 write addr 4 data 500, PREADY=1: READY[0] at c0, PSEL c1, PENABLE c2, PWDATA=500; RSP_VALID c3 with ID=0, ERR=0.
- Req1 read addr 8, PREADY low 3 ACCESS cycles, PRDATA=24: PENABLE held 4 cycles with PADDR=8 stable; RSP_RDATA=24, ID=1.
- Both request continuously (writes to 8 and 16): grant order 0,1,0,1. PSEL never drops between transfers; PENABLE low exactly 1 cycle between them.
- Reset pulsed low during ACCESS of write addr 56 data 66666: PSEL/PENABLE=0 immediately, no RSP_VALID. After release, req1+req0 pending results in req0 granted first.
- APB_TIMEOUT_EN defined, PREADY held 0: PSEL drops after 16 ACCESS cycles; RSP_VALID with ERR=1, RDATA=0. Next request proceeds normally.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared state encoding, default widths and timeout-counter sizing for apb_arb_master.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_t;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  // Counter must be able to hold the value TIMEOUT_CYC itself.
  function automatic int cnt_width(input int cyc);
    return $clog2(cyc + 1);
  endfunction

  localparam int TO_CNT_W_DEF = $clog2(TIMEOUT_CYC_DEF + 1);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer
// that advances only when the caller reports that the grant was taken.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant,
  output logic       o_grant_id
);

  logic r_prio;
  logic w_id;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    w_id = r_prio;
    if (i_req == 2'b01) begin
      w_id = 1'b0;
    end else if (i_req == 2'b10) begin
      w_id = 1'b1;
    end
  end

  assign o_grant_id = w_id;
  assign o_grant    = (i_req == 2'b00) ? 2'b00 : (w_id ? 2'b10 : 2'b01);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= 1'b0;
    end else if (i_update && (i_req != 2'b00)) begin
      r_prio <= ~w_id;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master sharing one slave between two requesters with round-robin arbitration.
// Optional ACCESS-phase timeout abort is enabled by defining APB_TIMEOUT_EN.
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                I_PCLK,
  input  logic                I_PRESET_N,
  input  logic [1:0]          I_REQ_VALID,
  input  logic [1:0]          I_REQ_WRITE,
  input  logic [2*ADDR_W-1:0] I_REQ_ADDR,
  input  logic [2*DATA_W-1:0] I_REQ_WDATA,
  output logic [1:0]          O_REQ_READY,
  output logic                O_RSP_VALID,
  output logic                O_RSP_ID,
  output logic [DATA_W-1:0]   O_RSP_RDATA,
  output logic                O_RSP_ERR,
  output logic                O_PSEL,
  output logic                O_PENABLE,
  output logic                O_PWRITE,
  output logic [ADDR_W-1:0]   O_PADDR,
  output logic [DATA_W-1:0]   O_PWDATA,
  input  logic [DATA_W-1:0]   I_PRDATA,
  input  logic                I_PREADY
);

  apb_state_t        r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_cmd_id;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic              w_any_req;
  logic              w_timeout;
  logic              w_can_grant;
  logic              w_grant_en;
  logic [1:0]        w_grant;
  logic              w_gid;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_any_req   = |I_REQ_VALID;
  // New work is accepted from IDLE, or on the completing ACCESS cycle for back-to-back.
  assign w_can_grant = (r_state == ST_IDLE) || ((r_state == ST_ACCESS) && I_PREADY);
  assign w_grant_en  = w_can_grant && w_any_req;

  rr_arb2 u_arb (
    .i_clk      (I_PCLK),
    .i_rst_n    (I_PRESET_N),
    .i_req      (I_REQ_VALID),
    .i_update   (w_grant_en),
    .o_grant    (w_grant),
    .o_grant_id (w_gid)
  );

  assign O_REQ_READY = w_grant_en ? w_grant : 2'b00;

  assign w_sel_write = w_gid ? I_REQ_WRITE[1] : I_REQ_WRITE[0];
  assign w_sel_addr  = w_gid ? I_REQ_ADDR[2*ADDR_W-1:ADDR_W]  : I_REQ_ADDR[ADDR_W-1:0];
  assign w_sel_wdata = w_gid ? I_REQ_WDATA[2*DATA_W-1:DATA_W] : I_REQ_WDATA[DATA_W-1:0];

  // Command registers double as the APB address/data/direction outputs, so they
  // keep their last values while idle.
  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_cmd_id <= 1'b0;
    end else if (w_grant_en) begin
      r_pwrite <= w_sel_write;
      r_paddr  <= w_sel_addr;
      r_pwdata <= w_sel_wdata;
      r_cmd_id <= w_gid;
    end
  end

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      r_state     <= ST_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (I_PREADY) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_cmd_id;
            r_rsp_rdata <= r_pwrite ? '0 : I_PRDATA;
            r_penable   <= 1'b0;
            if (w_any_req) begin
              r_state <= ST_SETUP;
            end else begin
              r_psel  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_cmd_id;
            r_rsp_rdata <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_rsp_err;

  // Fires on the ACCESS cycle whose stall would bring the count to TIMEOUT_CYC.
  assign w_timeout = (r_state == ST_ACCESS) && !I_PREADY &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge I_PCLK or negedge I_PRESET_N) begin
    if (!I_PRESET_N) begin
      r_to_cnt  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_err <= w_timeout;
      if (r_state == ST_SETUP) begin
        r_to_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !I_PREADY) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign O_RSP_ERR = r_rsp_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC == 0);
  assign w_timeout        = 1'b0;
  assign O_RSP_ERR        = 1'b0;
`endif

  assign O_PSEL      = r_psel;
  assign O_PENABLE   = r_penable;
  assign O_PWRITE    = r_pwrite;
  assign O_PADDR     = r_paddr;
  assign O_PWDATA    = r_pwdata;
  assign O_RSP_VALID = r_rsp_valid;
  assign O_RSP_ID    = r_rsp_id;
  assign O_RSP_RDATA = r_rsp_rdata;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed, table-driven bench for apb_arb_master plus hand sequences for
// mid-transfer reset and long PREADY stalls (timeout abort when APB_TIMEOUT_EN is set).
module tb_apb_arb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO_CYC = 16;
  localparam int NVEC = 24;

  logic            I_PCLK = 1'b0;
  logic            I_PRESET_N;
  logic [1:0]      I_REQ_VALID;
  logic [1:0]      I_REQ_WRITE;
  logic [2*AW-1:0] I_REQ_ADDR;
  logic [2*DW-1:0] I_REQ_WDATA;
  logic [1:0]      O_REQ_READY;
  logic            O_RSP_VALID;
  logic            O_RSP_ID;
  logic [DW-1:0]   O_RSP_RDATA;
  logic            O_RSP_ERR;
  logic            O_PSEL;
  logic            O_PENABLE;
  logic            O_PWRITE;
  logic [AW-1:0]   O_PADDR;
  logic [DW-1:0]   O_PWDATA;
  logic [DW-1:0]   I_PRDATA;
  logic            I_PREADY;

  int vecCount = 0;
  int missCount = 0;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        pready;
    logic [31:0] prdata;
    logic [1:0]  eReady;
    logic        ePsel;
    logic        ePen;
    logic [31:0] ePaddr;
    logic        ePwrite;
    logic [31:0] ePwdata;
    logic        eRspV;
    logic        eRspId;
    logic [31:0] eRdata;
  } vec_t;

  vec_t vecs [NVEC];

  apb_arb_master dut (
    .I_PCLK      (I_PCLK),
    .I_PRESET_N  (I_PRESET_N),
    .I_REQ_VALID (I_REQ_VALID),
    .I_REQ_WRITE (I_REQ_WRITE),
    .I_REQ_ADDR  (I_REQ_ADDR),
    .I_REQ_WDATA (I_REQ_WDATA),
    .O_REQ_READY (O_REQ_READY),
    .O_RSP_VALID (O_RSP_VALID),
    .O_RSP_ID    (O_RSP_ID),
    .O_RSP_RDATA (O_RSP_RDATA),
    .O_RSP_ERR   (O_RSP_ERR),
    .O_PSEL      (O_PSEL),
    .O_PENABLE   (O_PENABLE),
    .O_PWRITE    (O_PWRITE),
    .O_PADDR     (O_PADDR),
    .O_PWDATA    (O_PWDATA),
    .I_PRDATA    (I_PRDATA),
    .I_PREADY    (I_PREADY)
  );

  always #5 I_PCLK = ~I_PCLK;

  function automatic vec_t mk(
    input logic [1:0] valid, input logic [1:0] write,
    input logic [31:0] addr0, input logic [31:0] addr1,
    input logic [31:0] wd0, input logic [31:0] wd1,
    input logic pready, input logic [31:0] prdata,
    input logic [1:0] eReady, input logic ePsel, input logic ePen,
    input logic [31:0] ePaddr, input logic ePwrite, input logic [31:0] ePwdata,
    input logic eRspV, input logic eRspId, input logic [31:0] eRdata);
    vec_t v;
    v.valid = valid;   v.write = write;
    v.addr0 = addr0;   v.addr1 = addr1;
    v.wd0 = wd0;       v.wd1 = wd1;
    v.pready = pready; v.prdata = prdata;
    v.eReady = eReady; v.ePsel = ePsel;   v.ePen = ePen;
    v.ePaddr = ePaddr; v.ePwrite = ePwrite; v.ePwdata = ePwdata;
    v.eRspV = eRspV;   v.eRspId = eRspId; v.eRdata = eRdata;
    return v;
  endfunction

  task automatic checkVal(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    I_REQ_VALID = v.valid;
    I_REQ_WRITE = v.write;
    I_REQ_ADDR  = {v.addr1, v.addr0};
    I_REQ_WDATA = {v.wd1, v.wd0};
    I_PREADY    = v.pready;
    I_PRDATA    = v.prdata;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkVal({tag, ".ready"},  O_REQ_READY, v.eReady);
    checkVal({tag, ".psel"},   O_PSEL,      v.ePsel);
    checkVal({tag, ".pen"},    O_PENABLE,   v.ePen);
    checkVal({tag, ".paddr"},  O_PADDR,     v.ePaddr);
    checkVal({tag, ".pwrite"}, O_PWRITE,    v.ePwrite);
    checkVal({tag, ".pwdata"}, O_PWDATA,    v.ePwdata);
    checkVal({tag, ".rspv"},   O_RSP_VALID, v.eRspV);
    checkVal({tag, ".rdata"},  O_RSP_RDATA, v.eRdata);
    checkVal({tag, ".err"},    O_RSP_ERR,   1'b0);
    if (v.eRspV) checkVal({tag, ".rspid"}, O_RSP_ID, v.eRspId);
  endtask

  task automatic setReq(input logic [1:0] valid, input logic [1:0] write,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
    I_REQ_VALID = valid;
    I_REQ_WRITE = write;
    I_REQ_ADDR  = {a1, a0};
    I_REQ_WDATA = {d1, d0};
  endtask

  initial begin
    // Req0 write, req1 read with 3 wait states, then both requesting back to back.
    vecs[0]  = mk(2'b01, 2'b01, 4, 0, 500, 0, 1, 0,  2'b01, 0, 0, 0, 0, 0,   0, 0, 0);
    vecs[1]  = mk(2'b00, 2'b01, 4, 0, 500, 0, 1, 0,  2'b00, 1, 0, 4, 1, 500, 0, 0, 0);
    vecs[2]  = mk(2'b00, 2'b01, 4, 0, 500, 0, 1, 0,  2'b00, 1, 1, 4, 1, 500, 0, 0, 0);
    vecs[3]  = mk(2'b00, 2'b01, 4, 0, 500, 0, 1, 0,  2'b00, 0, 0, 4, 1, 500, 1, 0, 0);
    vecs[4]  = mk(2'b00, 2'b01, 4, 0, 500, 0, 1, 0,  2'b00, 0, 0, 4, 1, 500, 0, 0, 0);
    vecs[5]  = mk(2'b10, 2'b00, 0, 8, 0, 0, 0, 24,   2'b10, 0, 0, 4, 1, 500, 0, 0, 0);
    vecs[6]  = mk(2'b00, 2'b00, 0, 8, 0, 0, 0, 24,   2'b00, 1, 0, 8, 0, 0,   0, 0, 0);
    vecs[7]  = mk(2'b00, 2'b00, 0, 8, 0, 0, 0, 24,   2'b00, 1, 1, 8, 0, 0,   0, 0, 0);
    vecs[8]  = mk(2'b00, 2'b00, 0, 8, 0, 0, 0, 24,   2'b00, 1, 1, 8, 0, 0,   0, 0, 0);
    vecs[9]  = mk(2'b00, 2'b00, 0, 8, 0, 0, 0, 24,   2'b00, 1, 1, 8, 0, 0,   0, 0, 0);
    vecs[10] = mk(2'b00, 2'b00, 0, 8, 0, 0, 1, 24,   2'b00, 1, 1, 8, 0, 0,   0, 0, 0);
    vecs[11] = mk(2'b00, 2'b00, 0, 8, 0, 0, 1, 24,   2'b00, 0, 0, 8, 0, 0,   1, 1, 24);
    vecs[12] = mk(2'b00, 2'b00, 0, 8, 0, 0, 1, 24,   2'b00, 0, 0, 8, 0, 0,   0, 1, 24);
    vecs[13] = mk(2'b11, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b01, 0, 0, 8,  0, 0,     0, 0, 24);
    vecs[14] = mk(2'b11, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b00, 1, 0, 8,  1, 'hA0,  0, 0, 24);
    vecs[15] = mk(2'b11, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b10, 1, 1, 8,  1, 'hA0,  0, 0, 24);
    vecs[16] = mk(2'b11, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b00, 1, 0, 16, 1, 'hB1,  1, 0, 0);
    vecs[17] = mk(2'b11, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b01, 1, 1, 16, 1, 'hB1,  0, 0, 0);
    vecs[18] = mk(2'b11, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b00, 1, 0, 8,  1, 'hA0,  1, 1, 0);
    vecs[19] = mk(2'b11, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b10, 1, 1, 8,  1, 'hA0,  0, 0, 0);
    vecs[20] = mk(2'b00, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b00, 1, 0, 16, 1, 'hB1,  1, 0, 0);
    vecs[21] = mk(2'b00, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b00, 1, 1, 16, 1, 'hB1,  0, 0, 0);
    vecs[22] = mk(2'b00, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b00, 0, 0, 16, 1, 'hB1,  1, 1, 0);
    vecs[23] = mk(2'b00, 2'b11, 8, 16, 'hA0, 'hB1, 1, 0, 2'b00, 0, 0, 16, 1, 'hB1,  0, 0, 0);

    I_PRESET_N = 1'b0;
    setReq(2'b00, 2'b00, 0, 0, 0, 0);
    I_PREADY = 1'b0;
    I_PRDATA = '0;
    repeat (2) @(negedge I_PCLK);
    #1;
    checkVal("reset.psel", O_PSEL, 1'b0);
    checkVal("reset.rspv", O_RSP_VALID, 1'b0);
    I_PRESET_N = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge I_PCLK);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end

    // Reset in the middle of an ACCESS phase; req0 is granted so the pointer would favour req1.
    @(negedge I_PCLK);
    setReq(2'b01, 2'b01, 56, 0, 66666, 0);
    I_PREADY = 1'b0;
    #1 checkVal("rst.ready", O_REQ_READY, 2'b01);
    @(negedge I_PCLK);
    I_REQ_VALID = 2'b00;
    #1 checkVal("rst.setup_paddr", O_PADDR, 56);
    @(negedge I_PCLK);
    #1 checkVal("rst.access_pen", O_PENABLE, 1'b1);
    checkVal("rst.access_pwdata", O_PWDATA, 66666);
    #1 I_PRESET_N = 1'b0;
    #1 checkVal("rst.async_psel", O_PSEL, 1'b0);
    checkVal("rst.async_pen", O_PENABLE, 1'b0);
    @(negedge I_PCLK);
    #1 checkVal("rst.no_rsp", O_RSP_VALID, 1'b0);
    I_PRESET_N = 1'b1;
    I_PREADY = 1'b1;
    @(negedge I_PCLK);
    #1 checkVal("rst.no_rsp_after", O_RSP_VALID, 1'b0);
    setReq(2'b11, 2'b11, 'h20, 'h24, 1, 2);
    #1 checkVal("rst.both_ready", O_REQ_READY, 2'b01);
    @(negedge I_PCLK);
    I_REQ_VALID = 2'b10;
    #1 checkVal("rst.b2b_setup_paddr", O_PADDR, 'h20);
    checkVal("rst.b2b_setup_ready", O_REQ_READY, 2'b00);
    @(negedge I_PCLK);
    #1 checkVal("rst.b2b_access_ready", O_REQ_READY, 2'b10);
    @(negedge I_PCLK);
    I_REQ_VALID = 2'b00;
    #1 checkVal("rst.rsp0_valid", O_RSP_VALID, 1'b1);
    checkVal("rst.rsp0_id", O_RSP_ID, 1'b0);
    checkVal("rst.second_paddr", O_PADDR, 'h24);
    @(negedge I_PCLK);
    @(negedge I_PCLK);
    #1 checkVal("rst.rsp1_valid", O_RSP_VALID, 1'b1);
    checkVal("rst.rsp1_id", O_RSP_ID, 1'b1);

    // Long stall: slave holds PREADY low while returning non-zero data.
    @(negedge I_PCLK);
    setReq(2'b01, 2'b00, 'h40, 0, 0, 0);
    I_PREADY = 1'b0;
    I_PRDATA = 'hDEAD;
    #1 checkVal("stall.ready", O_REQ_READY, 2'b01);
    @(negedge I_PCLK);
    I_REQ_VALID = 2'b00;
    for (int i = 0; i < TO_CYC; i++) begin
      @(negedge I_PCLK);
      #1 checkVal($sformatf("stall.access%0d", i), {O_PSEL, O_PENABLE, O_RSP_VALID}, 3'b110);
    end
`ifdef APB_TIMEOUT_EN
    @(negedge I_PCLK);
    #1 checkVal("to.psel", {O_PSEL, O_PENABLE}, 2'b00);
    checkVal("to.rspv", O_RSP_VALID, 1'b1);
    checkVal("to.err", O_RSP_ERR, 1'b1);
    checkVal("to.rdata", O_RSP_RDATA, 0);
    I_PREADY = 1'b1;
    I_PRDATA = 'h77;
    setReq(2'b10, 2'b00, 0, 'h44, 0, 0);
    #1 checkVal("to.next_ready", O_REQ_READY, 2'b10);
    @(negedge I_PCLK);
    I_REQ_VALID = 2'b00;
    @(negedge I_PCLK);
    @(negedge I_PCLK);
    #1 checkVal("to.next_rspv", O_RSP_VALID, 1'b1);
    checkVal("to.next_err", O_RSP_ERR, 1'b0);
    checkVal("to.next_rdata", O_RSP_RDATA, 'h77);
`else
    repeat (4) begin
      @(negedge I_PCLK);
      #1 checkVal("stall.extra", {O_PSEL, O_PENABLE, O_RSP_VALID}, 3'b110);
    end
    I_PREADY = 1'b1;
    @(negedge I_PCLK);
    #1 checkVal("stall.rspv", O_RSP_VALID, 1'b1);
    checkVal("stall.err", O_RSP_ERR, 1'b0);
    checkVal("stall.rdata", O_RSP_RDATA, 'hDEAD);
    checkVal("stall.psel", O_PSEL, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
